// File: rtl/edge_arb_pkg.sv
// ---------------------------------------------------------------------------
// edge_arb_pkg : shared FSM encodings and edge polarity constants
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package edge_arb_pkg;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  localparam logic POL_FALL = 1'b0;
  localparam logic POL_RISE = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = S_IDLE,
    ST_OFFER = S_OFFER
  } state_t;

endpackage

`default_nettype wire

// File: rtl/edge_event_slot.sv
// ---------------------------------------------------------------------------
// edge_event_slot : per-line edge detector with a two-entry event queue
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module edge_event_slot
  import edge_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level,
  input  logic pop,
  input  logic ovf_clr,
  output logic has_event,
  output logic oldest_pol,
  output logic ovf
);

  logic prev_reg;
  logic pend_r;
  logic pend_f;
  logic first;
  logic ovf_reg;

  logic rise;
  logic fall;
  logic r_after;
  logic f_after;
  logic drop;

  // The pop is applied before the new edge so overflow is judged on the
  // queue as it stands after removal.
  always_comb begin
    rise    = level & ~prev_reg;
    fall    = ~level & prev_reg;
    r_after = pend_r;
    f_after = pend_f;
    if (pop) begin
      if (pend_r && pend_f) begin
        if (first) r_after = 1'b0;
        else       f_after = 1'b0;
      end else begin
        r_after = 1'b0;
        f_after = 1'b0;
      end
    end
    drop = (rise && r_after) || (fall && f_after);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_reg <= 1'b0;
      pend_r   <= 1'b0;
      pend_f   <= 1'b0;
      first    <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      prev_reg <= level;
      pend_r   <= r_after | rise;
      pend_f   <= f_after | fall;
      if (rise && !r_after)      first <= ~f_after;
      else if (fall && !f_after) first <= r_after;
      if (drop)         ovf_reg <= 1'b1;
      else if (ovf_clr) ovf_reg <= 1'b0;
    end
  end

  assign has_event  = pend_r | pend_f;
  assign oldest_pol = (pend_r && pend_f) ? (first ? POL_RISE : POL_FALL)
                                         : (pend_r ? POL_RISE : POL_FALL);
  assign ovf        = ovf_reg;

endmodule

`default_nettype wire

// File: rtl/edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// edge_event_arbiter : round-robin merge of per-line edge events onto one
//                      valid/ready event port with sticky overflow flags
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   in,
  input  logic           ev_ready,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  output logic           ev_rise,
  output logic [N-1:0]   ovf,
  input  logic           ovf_clr
);

  state_t         state;
  logic [IDW-1:0] rr_ptr;
  logic [N-1:0]   has_event;
  logic [N-1:0]   oldest_pol;
  logic [N-1:0]   pop;
  logic           accept;
  logic           found;
  logic [IDW-1:0] gnt_id;
  logic           gnt_pol;

  assign accept = (state == ST_OFFER) && ev_ready;

  for (genvar i = 0; i < N; i++) begin : g_slot
    assign pop[i] = accept && (ev_id == IDW'(i));

    edge_event_slot u_slot (
      .clk        (clk),
      .reset      (reset),
      .level      (in[i]),
      .pop        (pop[i]),
      .ovf_clr    (ovf_clr),
      .has_event  (has_event[i]),
      .oldest_pol (oldest_pol[i]),
      .ovf        (ovf[i])
    );
  end

  // Scan starts just after the last granted line so every line gets a turn.
  always_comb begin
    logic [IDW-1:0] idx;
    idx     = '0;
    found   = 1'b0;
    gnt_id  = '0;
    gnt_pol = POL_FALL;
    for (int k = 1; k <= N; k++) begin
      idx = IDW'((int'(rr_ptr) + k) % N);
      if (!found && has_event[idx]) begin
        found   = 1'b1;
        gnt_id  = idx;
        gnt_pol = oldest_pol[idx];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      ev_valid <= 1'b0;
      ev_id    <= '0;
      ev_rise  <= 1'b0;
      rr_ptr   <= IDW'(N - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            ev_id    <= gnt_id;
            ev_rise  <= gnt_pol;
            ev_valid <= 1'b1;
            state    <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (ev_ready) begin
            rr_ptr   <= ev_id;
            ev_valid <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: begin
          ev_valid <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_edge_event_arbiter : directed and random checks against a queue model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           reset;
  logic [N-1:0]   in_lines;
  logic           ev_ready;
  logic           ev_valid;
  logic [IDW-1:0] ev_id;
  logic           ev_rise;
  logic [N-1:0]   ovf;
  logic           ovf_clr;

  int checks;
  int errors;

  // Reference model: each line owns a FIFO of edge polarities.
  bit mq [N][$];
  bit mprev [N];
  bit movf [N];
  int mrr;
  bit mvalid;
  int mid;
  bit mrise;

  // Events the DUT actually handed over (valid && ready at a clock edge).
  int got_id [$];
  bit got_rise [$];

  edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk      (clk),
    .reset    (reset),
    .in       (in_lines),
    .ev_ready (ev_ready),
    .ev_valid (ev_valid),
    .ev_id    (ev_id),
    .ev_rise  (ev_rise),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      mprev[i] = 1'b0;
      movf[i]  = 1'b0;
    end
    mrr = N - 1; mvalid = 1'b0; mid = 0; mrise = 1'b0;
  endtask

  task automatic model_edge();
    bit nvalid; int nid; bit nrise; bit dup;
    nvalid = mvalid; nid = mid; nrise = mrise;
    if (mvalid && ev_ready) begin
      void'(mq[mid].pop_front());
      mrr = mid;
      nvalid = 1'b0;
    end else if (!mvalid) begin
      for (int k = 1; k <= N; k++) begin
        if (!nvalid && mq[(mrr + k) % N].size() > 0) begin
          nvalid = 1'b1;
          nid    = (mrr + k) % N;
          nrise  = mq[nid][0];
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      dup = 1'b0;
      if (in_lines[i] != mprev[i]) begin
        for (int j = 0; j < mq[i].size(); j++)
          if (mq[i][j] == in_lines[i]) dup = 1'b1;
        if (dup) movf[i] = 1'b1;
        else     mq[i].push_back(in_lines[i]);
      end
      if (!dup && ovf_clr) movf[i] = 1'b0;
      mprev[i] = in_lines[i];
    end
    mvalid = nvalid; mid = nid; mrise = nrise;
  endtask

  function automatic logic [N+IDW+1:0] dut_view();
    return {ev_valid, ev_valid ? ev_id : IDW'(0), ev_valid & ev_rise, ovf};
  endfunction

  function automatic logic [N+IDW+1:0] model_view();
    logic [N-1:0] o;
    for (int i = 0; i < N; i++) o[i] = movf[i];
    return {mvalid, mvalid ? IDW'(mid) : IDW'(0), mvalid & mrise, o};
  endfunction

  task automatic tick();
    if (ev_valid === 1'b1 && ev_ready === 1'b1 && !reset) begin
      got_id.push_back(int'(ev_id));
      got_rise.push_back(ev_rise);
    end
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_lines = '0; ev_ready = 1'b0; ovf_clr = 1'b0; reset = 1'b1;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    got_id.delete(); got_rise.delete();
  endtask

  task automatic test_reset();
    in_lines = '0; ev_ready = 1'b1; ovf_clr = 1'b0; reset = 1'b1;
    model_reset();
    tick(); tick();
    checks++;
    if ({ev_valid, ev_id, ev_rise, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_values: got valid=%b id=%0d rise=%b ovf=%b want all zero",
               ev_valid, ev_id, ev_rise, ovf);
    end
    checks++;
    if (dut.rr_ptr !== IDW'(N - 1)) begin
      errors++;
      $display("FAIL reset_rr_ptr: got %0d want %0d", dut.rr_ptr, N - 1);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (dut_view() !== model_view()) begin
      errors++;
      $display("FAIL reset_idle: got %b want %b", dut_view(), model_view());
    end
  endtask

  task automatic test_single_pulse();
    do_reset();
    ev_ready = 1'b1; in_lines = 4'b0100;
    tick();
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL pulse_early_valid: got %b want 0", ev_valid);
    end
    in_lines = 4'b0000;
    tick();
    checks++;
    if ({ev_valid, ev_id, ev_rise} !== {1'b1, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL pulse_first_offer: got valid=%b id=%0d rise=%b want 1/2/1",
               ev_valid, ev_id, ev_rise);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL pulse_model c%0d: got %b want %b", c, dut_view(), model_view());
      end
    end
    checks++;
    if (got_id.size() != 2 || got_id[0] != 2 || got_rise[0] != 1'b1 ||
        got_id[1] != 2 || got_rise[1] != 1'b0) begin
      errors++;
      $display("FAIL pulse_sequence: got ids %p pols %p want ids 2,2 pols 1,0", got_id, got_rise);
    end
  endtask

  task automatic test_three_lines();
    do_reset();
    ev_ready = 1'b1; in_lines = 4'b1011;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL rr_model c%0d: got %b want %b", c, dut_view(), model_view());
      end
    end
    checks++;
    if (got_id.size() != 3 || got_id[0] != 0 || got_id[1] != 1 || got_id[2] != 3) begin
      errors++;
      $display("FAIL rr_order: got ids %p want 0,1,3", got_id);
    end
    checks++;
    if (dut.rr_ptr !== 2'd3) begin
      errors++;
      $display("FAIL rr_ptr_end: got %0d want 3", dut.rr_ptr);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    ev_ready = 1'b0;
    in_lines = 4'b0010; tick();
    in_lines = 4'b0000; tick();
    in_lines = 4'b0010; tick();
    tick();
    checks++;
    if (ovf !== 4'b0010 || {ev_valid, ev_id, ev_rise} !== {1'b1, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b valid=%b id=%0d rise=%b want 0010/1/1/1",
               ovf, ev_valid, ev_id, ev_rise);
    end
    ev_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL ovf_model c%0d: got %b want %b", c, dut_view(), model_view());
      end
    end
    checks++;
    if (got_id.size() != 2 || got_id[0] != 1 || got_rise[0] != 1'b1 ||
        got_id[1] != 1 || got_rise[1] != 1'b0) begin
      errors++;
      $display("FAIL ovf_delivery: got ids %p pols %p want ids 1,1 pols 1,0", got_id, got_rise);
    end
    checks++;
    if (ovf !== 4'b0010) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 0010", ovf);
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    checks++;
    if (ovf !== 4'b0000) begin
      errors++;
      $display("FAIL ovf_clear: got %b want 0000", ovf);
    end
  endtask

  task automatic test_pop_append();
    do_reset();
    ev_ready = 1'b0;
    in_lines = 4'b0010; tick();
    in_lines = 4'b0000; tick();
    ev_ready = 1'b1; in_lines = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL popapp_model c%0d: got %b want %b", c, dut_view(), model_view());
      end
    end
    checks++;
    if (ovf !== 4'b0000) begin
      errors++;
      $display("FAIL popapp_ovf: got %b want 0000", ovf);
    end
    checks++;
    if (got_id.size() != 3 || got_rise[0] != 1'b1 || got_rise[1] != 1'b0 ||
        got_rise[2] != 1'b1 || got_id[2] != 1) begin
      errors++;
      $display("FAIL popapp_sequence: got ids %p pols %p want ids 1,1,1 pols 1,0,1", got_id, got_rise);
    end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    ev_ready = 1'b0; in_lines = 4'b0001;
    tick(); tick();
    checks++;
    if (ev_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_offer: got valid=%b want 1", ev_valid);
    end
    in_lines = 4'b0100;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ev_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async_drop: got valid=%b want 0", ev_valid);
    end
    model_reset();
    tick();
    reset = 1'b0;
    got_id.delete(); got_rise.delete();
    ev_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL midrst_model c%0d: got %b want %b", c, dut_view(), model_view());
      end
    end
    checks++;
    if (got_id.size() != 1 || got_id[0] != 2 || got_rise[0] != 1'b1) begin
      errors++;
      $display("FAIL midrst_sequence: got ids %p pols %p want id 2 pol 1", got_id, got_rise);
    end
  endtask

  task automatic test_hold_stable();
    do_reset();
    ev_ready = 1'b0; in_lines = 4'b1000;
    tick(); tick();
    for (int c = 0; c < 10; c++) begin
      in_lines = {1'b1, 3'($urandom)};
      tick();
      checks++;
      if ({ev_valid, ev_id, ev_rise} !== {1'b1, 2'd3, 1'b1} || dut_view() !== model_view()) begin
        errors++;
        $display("FAIL hold_stable c%0d: got %b want %b (id 3 rise)", c, dut_view(), model_view());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      in_lines = N'($urandom);
      ev_ready = ($urandom_range(0, 9) < 7);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      tick();
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL random_model c%0d: got %b want %b", c, dut_view(), model_view());
      end
    end
    in_lines = '0; ovf_clr = 1'b0; ev_ready = 1'b1;
    for (int c = 0; c < 24; c++) begin
      tick();
      checks++;
      if (dut_view() !== model_view()) begin
        errors++;
        $display("FAIL random_drain c%0d: got %b want %b", c, dut_view(), model_view());
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; in_lines = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    test_reset();
    test_single_pulse();
    test_three_lines();
    test_overflow();
    test_pop_append();
    test_reset_mid_offer();
    test_hold_stable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

`default_nettype wire
